ysyx_23060025_axi_arbiter: RTL and testbench

Two-master to one-slave AXI-lite arbiter placed directly upstream of the AXI SRAM slave. The IFU uses it for read-only instruction fetch and the LSU uses it for reads and writes. It admits exactly one outstanding transaction at a time. It routes address, data and response channels between the granted master and the slave, and it holds the grant until that transaction's response handshake completes.

---
 rtl/ysyx_23060025_axi_arbiter.sv | 153 +++++++++++++++
 tb/tb_ysyx_23060025_axi_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060025_axi_arbiter.sv
// Two-master (IFU, LSU) to one-slave AXI-lite arbiter.
// One outstanding transaction; grant held until its response handshake.
module ysyx_23060025_axi_arbiter #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [ADDR_LEN-1:0] ifu_ar_addr_i,
  input  logic                ifu_ar_valid_i,
  output logic                ifu_ar_ready_o,
  output logic [DATA_LEN-1:0] ifu_r_data_o,
  output logic [1:0]          ifu_r_resp_o,
  output logic                ifu_r_valid_o,
  input  logic                ifu_r_ready_i,
  input  logic [ADDR_LEN-1:0] lsu_ar_addr_i,
  input  logic                lsu_ar_valid_i,
  output logic                lsu_ar_ready_o,
  output logic [DATA_LEN-1:0] lsu_r_data_o,
  output logic [1:0]          lsu_r_resp_o,
  output logic                lsu_r_valid_o,
  input  logic                lsu_r_ready_i,
  input  logic [ADDR_LEN-1:0] lsu_aw_addr_i,
  input  logic                lsu_aw_valid_i,
  output logic                lsu_aw_ready_o,
  input  logic [DATA_LEN-1:0] lsu_w_data_i,
  input  logic [3:0]          lsu_w_strb_i,
  input  logic                lsu_w_valid_i,
  output logic                lsu_w_ready_o,
  output logic [1:0]          lsu_b_resp_o,
  output logic                lsu_b_valid_o,
  input  logic                lsu_b_ready_i,
  output logic [ADDR_LEN-1:0] s_ar_addr_o,
  output logic                s_ar_valid_o,
  input  logic                s_ar_ready_i,
  input  logic [DATA_LEN-1:0] s_r_data_i,
  input  logic [1:0]          s_r_resp_i,
  input  logic                s_r_valid_i,
  output logic                s_r_ready_o,
  output logic [ADDR_LEN-1:0] s_aw_addr_o,
  output logic                s_aw_valid_o,
  input  logic                s_aw_ready_i,
  output logic [DATA_LEN-1:0] s_w_data_o,
  output logic [3:0]          s_w_strb_o,
  output logic                s_w_valid_o,
  input  logic                s_w_ready_i,
  input  logic [1:0]          s_b_resp_i,
  input  logic                s_b_valid_i,
  output logic                s_b_ready_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } state_t;

  state_t state, nxt;
  logic   ar_done, aw_done, w_done;
  logic   ar_hs, aw_hs, w_hs, r_hs, b_hs;

  assign ar_hs = s_ar_valid_o & s_ar_ready_i;
  assign aw_hs = s_aw_valid_o & s_aw_ready_i;
  assign w_hs  = s_w_valid_o & s_w_ready_i;
  assign r_hs  = s_r_valid_i & s_r_ready_o;
  assign b_hs  = s_b_valid_i & s_b_ready_o;

  assign ifu_r_data_o = s_r_data_i;
  assign ifu_r_resp_o = s_r_resp_i;
  assign lsu_r_data_o = s_r_data_i;
  assign lsu_r_resp_o = s_r_resp_i;
  assign lsu_b_resp_o = s_b_resp_i;
  assign s_w_data_o   = lsu_w_data_i;
  assign s_w_strb_o   = lsu_w_strb_i;
  assign s_aw_addr_o  = lsu_aw_addr_i;
  assign s_ar_addr_o  = (state == IFU_RD) ? ifu_ar_addr_i
                                          : lsu_ar_addr_i;

  always_ff @(posedge clk) begin
    if (rstn) begin
      state   <= IDLE;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= nxt;
      // every grant is entered from IDLE, so clearing here covers entry
      if (state == IDLE) begin
        ar_done <= 1'b0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        ar_done <= ar_done | ar_hs;
        aw_done <= aw_done | aw_hs;
        w_done  <= w_done | w_hs;
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (lsu_aw_valid_i | lsu_w_valid_i) nxt = LSU_WR;
        else if (lsu_ar_valid_i)            nxt = LSU_RD;
        else if (ifu_ar_valid_i)            nxt = IFU_RD;
      end
      IFU_RD, LSU_RD: if (r_hs) nxt = IDLE;
      LSU_WR:         if (b_hs) nxt = IDLE;
      default:        nxt = IDLE;
    endcase
  end

  always_comb begin
    ifu_ar_ready_o = 1'b0;
    ifu_r_valid_o  = 1'b0;
    lsu_ar_ready_o = 1'b0;
    lsu_r_valid_o  = 1'b0;
    lsu_aw_ready_o = 1'b0;
    lsu_w_ready_o  = 1'b0;
    lsu_b_valid_o  = 1'b0;
    s_ar_valid_o   = 1'b0;
    s_r_ready_o    = 1'b0;
    s_aw_valid_o   = 1'b0;
    s_w_valid_o    = 1'b0;
    s_b_ready_o    = 1'b0;
    case (state)
      IFU_RD: begin
        s_ar_valid_o   = ifu_ar_valid_i & ~ar_done;
        ifu_ar_ready_o = s_ar_ready_i & ~ar_done;
        ifu_r_valid_o  = s_r_valid_i;
        s_r_ready_o    = ifu_r_ready_i;
      end
      LSU_RD: begin
        s_ar_valid_o   = lsu_ar_valid_i & ~ar_done;
        lsu_ar_ready_o = s_ar_ready_i & ~ar_done;
        lsu_r_valid_o  = s_r_valid_i;
        s_r_ready_o    = lsu_r_ready_i;
      end
      LSU_WR: begin
        s_aw_valid_o   = lsu_aw_valid_i & ~aw_done;
        lsu_aw_ready_o = s_aw_ready_i & ~aw_done;
        s_w_valid_o    = lsu_w_valid_i & ~w_done;
        lsu_w_ready_o  = s_w_ready_i & ~w_done;
        lsu_b_valid_o  = s_b_valid_i;
        s_b_ready_o    = lsu_b_ready_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060025_axi_arbiter.sv
// Directed bench for the IFU/LSU AXI-lite arbiter.
// Slave and masters are driven by hand, one cycle at a time.
module tb_ysyx_23060025_axi_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] ifu_ar_addr_i;
  logic        ifu_ar_valid_i, ifu_ar_ready_o;
  logic [31:0] ifu_r_data_o;
  logic [1:0]  ifu_r_resp_o;
  logic        ifu_r_valid_o, ifu_r_ready_i;
  logic [31:0] lsu_ar_addr_i;
  logic        lsu_ar_valid_i, lsu_ar_ready_o;
  logic [31:0] lsu_r_data_o;
  logic [1:0]  lsu_r_resp_o;
  logic        lsu_r_valid_o, lsu_r_ready_i;
  logic [31:0] lsu_aw_addr_i;
  logic        lsu_aw_valid_i, lsu_aw_ready_o;
  logic [31:0] lsu_w_data_i;
  logic [3:0]  lsu_w_strb_i;
  logic        lsu_w_valid_i, lsu_w_ready_o;
  logic [1:0]  lsu_b_resp_o;
  logic        lsu_b_valid_o, lsu_b_ready_i;
  logic [31:0] s_ar_addr_o;
  logic        s_ar_valid_o, s_ar_ready_i;
  logic [31:0] s_r_data_i;
  logic [1:0]  s_r_resp_i;
  logic        s_r_valid_i, s_r_ready_o;
  logic [31:0] s_aw_addr_o;
  logic        s_aw_valid_o, s_aw_ready_i;
  logic [31:0] s_w_data_o;
  logic [3:0]  s_w_strb_o;
  logic        s_w_valid_o, s_w_ready_i;
  logic [1:0]  s_b_resp_i;
  logic        s_b_valid_i, s_b_ready_o;

  int tests = 0;
  int fails = 0;

  ysyx_23060025_axi_arbiter dut (
    .clk(clk), .rstn(rstn),
    .ifu_ar_addr_i(ifu_ar_addr_i),
    .ifu_ar_valid_i(ifu_ar_valid_i),
    .ifu_ar_ready_o(ifu_ar_ready_o),
    .ifu_r_data_o(ifu_r_data_o),
    .ifu_r_resp_o(ifu_r_resp_o),
    .ifu_r_valid_o(ifu_r_valid_o),
    .ifu_r_ready_i(ifu_r_ready_i),
    .lsu_ar_addr_i(lsu_ar_addr_i),
    .lsu_ar_valid_i(lsu_ar_valid_i),
    .lsu_ar_ready_o(lsu_ar_ready_o),
    .lsu_r_data_o(lsu_r_data_o),
    .lsu_r_resp_o(lsu_r_resp_o),
    .lsu_r_valid_o(lsu_r_valid_o),
    .lsu_r_ready_i(lsu_r_ready_i),
    .lsu_aw_addr_i(lsu_aw_addr_i),
    .lsu_aw_valid_i(lsu_aw_valid_i),
    .lsu_aw_ready_o(lsu_aw_ready_o),
    .lsu_w_data_i(lsu_w_data_i),
    .lsu_w_strb_i(lsu_w_strb_i),
    .lsu_w_valid_i(lsu_w_valid_i),
    .lsu_w_ready_o(lsu_w_ready_o),
    .lsu_b_resp_o(lsu_b_resp_o),
    .lsu_b_valid_o(lsu_b_valid_o),
    .lsu_b_ready_i(lsu_b_ready_i),
    .s_ar_addr_o(s_ar_addr_o),
    .s_ar_valid_o(s_ar_valid_o),
    .s_ar_ready_i(s_ar_ready_i),
    .s_r_data_i(s_r_data_i),
    .s_r_resp_i(s_r_resp_i),
    .s_r_valid_i(s_r_valid_i),
    .s_r_ready_o(s_r_ready_o),
    .s_aw_addr_o(s_aw_addr_o),
    .s_aw_valid_o(s_aw_valid_o),
    .s_aw_ready_i(s_aw_ready_i),
    .s_w_data_o(s_w_data_o),
    .s_w_strb_o(s_w_strb_o),
    .s_w_valid_o(s_w_valid_o),
    .s_w_ready_i(s_w_ready_i),
    .s_b_resp_i(s_b_resp_i),
    .s_b_valid_i(s_b_valid_i),
    .s_b_ready_o(s_b_ready_o)
  );

  always #5 clk = ~clk;

  // all 12 handshake outputs, master side then slave side
  logic [11:0] vr;
  assign vr = {ifu_ar_ready_o, ifu_r_valid_o,
               lsu_ar_ready_o, lsu_r_valid_o,
               lsu_aw_ready_o, lsu_w_ready_o,
               lsu_b_valid_o, s_ar_valid_o,
               s_r_ready_o, s_aw_valid_o,
               s_w_valid_o, s_b_ready_o};

  logic [4:0] lsu_vr;
  assign lsu_vr = {lsu_ar_ready_o, lsu_r_valid_o,
                   lsu_aw_ready_o, lsu_w_ready_o,
                   lsu_b_valid_o};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // advance one cycle; inputs are then changed #1 after posedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic ifu_read(input logic [31:0] a,
                          input logic [31:0] d,
                          input string t);
    ifu_ar_addr_i  = a;
    ifu_ar_valid_i = 1'b1;
    settle();
    chk({t, "_idle"}, 32'(vr), 32'h0);
    tick();
    settle();
    chk({t, "_araddr"}, s_ar_addr_o, a);
    chk({t, "_arv"}, 32'(s_ar_valid_o), 32'h1);
    chk({t, "_arrdy"}, 32'(ifu_ar_ready_o), 32'h1);
    chk({t, "_lsu0"}, 32'(lsu_vr), 32'h0);
    tick();
    ifu_ar_valid_i = 1'b0;
    s_r_valid_i    = 1'b1;
    s_r_data_i     = d;
    s_r_resp_i     = 2'b00;
    settle();
    chk({t, "_rv"}, 32'(ifu_r_valid_o), 32'h1);
    chk({t, "_rdata"}, ifu_r_data_o, d);
    chk({t, "_rrdy"}, 32'(s_r_ready_o), 32'h1);
    chk({t, "_lsu0b"}, 32'(lsu_vr), 32'h0);
    tick();
    s_r_valid_i = 1'b0;
    settle();
    chk({t, "_back"}, 32'(vr), 32'h0);
  endtask

  initial begin
    rstn           = 1'b1;
    ifu_ar_addr_i  = '0;
    ifu_ar_valid_i = 1'b0;
    ifu_r_ready_i  = 1'b1;
    lsu_ar_addr_i  = '0;
    lsu_ar_valid_i = 1'b0;
    lsu_r_ready_i  = 1'b1;
    lsu_aw_addr_i  = '0;
    lsu_aw_valid_i = 1'b0;
    lsu_w_data_i   = '0;
    lsu_w_strb_i   = '0;
    lsu_w_valid_i  = 1'b0;
    lsu_b_ready_i  = 1'b1;
    s_ar_ready_i   = 1'b1;
    s_r_data_i     = '0;
    s_r_resp_i     = '0;
    s_r_valid_i    = 1'b0;
    s_aw_ready_i   = 1'b1;
    s_w_ready_i    = 1'b1;
    s_b_resp_i     = '0;
    s_b_valid_i    = 1'b0;

    tick();
    tick();
    rstn = 1'b0;
    settle();
    chk("reset_vr", 32'(vr), 32'h0);

    // single IFU read
    ifu_read(32'h8000_0004, 32'hDEAD_BEEF, "ifu1");

    // simultaneous IFU and LSU reads: LSU wins
    ifu_ar_addr_i  = 32'h8000_0100;
    ifu_ar_valid_i = 1'b1;
    lsu_ar_addr_i  = 32'h8000_0020;
    lsu_ar_valid_i = 1'b1;
    tick();
    settle();
    chk("sim_araddr", s_ar_addr_o, 32'h8000_0020);
    chk("sim_lsu_arrdy", 32'(lsu_ar_ready_o), 32'h1);
    chk("sim_ifu_arrdy", 32'(ifu_ar_ready_o), 32'h0);
    tick();
    lsu_ar_valid_i = 1'b0;
    s_r_valid_i    = 1'b1;
    s_r_data_i     = 32'h1111_2222;
    s_r_resp_i     = 2'b10;
    settle();
    chk("sim_lsu_rv", 32'(lsu_r_valid_o), 32'h1);
    chk("sim_lsu_rresp", 32'(lsu_r_resp_o), 32'h2);
    chk("sim_ifu_rv", 32'(ifu_r_valid_o), 32'h0);
    chk("sim_ifu_arrdy2", 32'(ifu_ar_ready_o), 32'h0);
    tick();
    s_r_valid_i = 1'b0;
    settle();
    chk("sim_idle", 32'(vr), 32'h0);
    tick();
    settle();
    chk("sim_ifu_grant", 32'(ifu_ar_ready_o), 32'h1);
    chk("sim_ifu_addr", s_ar_addr_o, 32'h8000_0100);
    tick();
    ifu_ar_valid_i = 1'b0;
    s_r_valid_i    = 1'b1;
    s_r_data_i     = 32'h3333_4444;
    s_r_resp_i     = 2'b00;
    settle();
    chk("sim_ifu_rdata", ifu_r_data_o, 32'h3333_4444);
    chk("sim_ifu_rv2", 32'(ifu_r_valid_o), 32'h1);
    tick();
    s_r_valid_i = 1'b0;
    settle();
    chk("sim_idle2", 32'(vr), 32'h0);

    // LSU write
    lsu_aw_addr_i  = 32'h8000_0010;
    lsu_w_data_i   = 32'h1234_5678;
    lsu_w_strb_i   = 4'b0011;
    lsu_aw_valid_i = 1'b1;
    lsu_w_valid_i  = 1'b1;
    tick();
    settle();
    chk("wr_awv", 32'(s_aw_valid_o), 32'h1);
    chk("wr_wv", 32'(s_w_valid_o), 32'h1);
    chk("wr_awrdy", 32'(lsu_aw_ready_o), 32'h1);
    chk("wr_wrdy", 32'(lsu_w_ready_o), 32'h1);
    chk("wr_awaddr", s_aw_addr_o, 32'h8000_0010);
    chk("wr_wdata", s_w_data_o, 32'h1234_5678);
    chk("wr_wstrb", 32'(s_w_strb_o), 32'h3);
    tick();
    lsu_aw_valid_i = 1'b0;
    lsu_w_valid_i  = 1'b0;
    s_b_valid_i    = 1'b1;
    s_b_resp_i     = 2'b00;
    settle();
    chk("wr_bv", 32'(lsu_b_valid_o), 32'h1);
    chk("wr_bresp", 32'(lsu_b_resp_o), 32'h0);
    chk("wr_brdy", 32'(s_b_ready_o), 32'h1);
    tick();
    s_b_valid_i = 1'b0;
    settle();
    chk("wr_idle", 32'(vr), 32'h0);

    // R back-pressure; AR valid held high to probe ar_done gating
    lsu_ar_addr_i  = 32'h8000_0040;
    lsu_ar_valid_i = 1'b1;
    lsu_r_ready_i  = 1'b0;
    tick();
    settle();
    chk("bp_arrdy", 32'(lsu_ar_ready_o), 32'h1);
    tick();
    s_r_valid_i = 1'b1;
    s_r_data_i  = 32'h5555_6666;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_rv", 32'(lsu_r_valid_o), 32'h1);
      chk("bp_srrdy", 32'(s_r_ready_o), 32'h0);
      chk("bp_noar", 32'(s_ar_valid_o), 32'h0);
      chk("bp_noarrdy", 32'(lsu_ar_ready_o), 32'h0);
      tick();
    end
    lsu_ar_valid_i = 1'b0;
    lsu_r_ready_i  = 1'b1;
    settle();
    chk("bp_srrdy1", 32'(s_r_ready_o), 32'h1);
    chk("bp_rdata", lsu_r_data_o, 32'h5555_6666);
    tick();
    s_r_valid_i = 1'b0;
    settle();
    chk("bp_idle", 32'(vr), 32'h0);

    // write over read; W accepted a cycle after AW
    lsu_aw_valid_i = 1'b1;
    lsu_w_valid_i  = 1'b1;
    lsu_ar_valid_i = 1'b1;
    lsu_ar_addr_i  = 32'h8000_0080;
    s_w_ready_i    = 1'b0;
    tick();
    settle();
    chk("pr_awrdy", 32'(lsu_aw_ready_o), 32'h1);
    chk("pr_wrdy0", 32'(lsu_w_ready_o), 32'h0);
    chk("pr_arrdy0", 32'(lsu_ar_ready_o), 32'h0);
    chk("pr_sarv0", 32'(s_ar_valid_o), 32'h0);
    tick();
    s_w_ready_i = 1'b1;
    settle();
    chk("pr_aw_once", 32'(s_aw_valid_o), 32'h0);
    chk("pr_wrdy1", 32'(lsu_w_ready_o), 32'h1);
    chk("pr_wv", 32'(s_w_valid_o), 32'h1);
    tick();
    lsu_aw_valid_i = 1'b0;
    lsu_w_valid_i  = 1'b0;
    s_b_valid_i    = 1'b1;
    s_b_resp_i     = 2'b11;
    settle();
    chk("pr_w_once", 32'(s_w_valid_o), 32'h0);
    chk("pr_bv", 32'(lsu_b_valid_o), 32'h1);
    chk("pr_bresp", 32'(lsu_b_resp_o), 32'h3);
    tick();
    s_b_valid_i = 1'b0;
    settle();
    chk("pr_idle", 32'(vr), 32'h0);
    tick();
    settle();
    chk("pr_rd_grant", 32'(lsu_ar_ready_o), 32'h1);
    chk("pr_rd_addr", s_ar_addr_o, 32'h8000_0080);
    tick();
    lsu_ar_valid_i = 1'b0;
    s_r_valid_i    = 1'b1;
    settle();
    chk("pr_rd_rv", 32'(lsu_r_valid_o), 32'h1);
    tick();
    s_r_valid_i = 1'b0;
    settle();
    chk("pr_idle2", 32'(vr), 32'h0);

    // reset mid-write with the slave stalling AW and W
    s_aw_ready_i   = 1'b0;
    s_w_ready_i    = 1'b0;
    lsu_aw_valid_i = 1'b1;
    lsu_w_valid_i  = 1'b1;
    tick();
    settle();
    chk("rst_awv", 32'(s_aw_valid_o), 32'h1);
    rstn = 1'b1;
    tick();
    settle();
    chk("rst_vr", 32'(vr), 32'h0);
    lsu_aw_valid_i = 1'b0;
    lsu_w_valid_i  = 1'b0;
    s_aw_ready_i   = 1'b1;
    s_w_ready_i    = 1'b1;
    rstn           = 1'b0;
    tick();
    ifu_read(32'h8000_0008, 32'hCAFE_F00D, "ifu2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
